lsrt_sched: RTL and testbench

LSRT_SCHED -- requirements
Module: lsrt_sched

---
 rtl/lsrt_sched.sv | 151 +++++++++++++++
 tb/tb_lsrt_sched.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsrt_sched.sv
// Round-robin scheduler granting NREQ requesters turns on one shared lstx transmitter.
// Optional transfer timeout with CLEAR abort is built when LSRT_SCHED_TIMEOUT_EN is defined.
module lsrt_sched #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned DMSB = 9,
    parameter int unsigned TMSB = 15
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       setn,
    input  logic [NREQ-1:0]            req,
    input  logic [NREQ*(DMSB+1)-1:0]   wdata_in,
    output logic [NREQ-1:0]            gnt,
    output logic [NREQ-1:0]            done,
    output logic                       busy,
    output logic                       tx_push,
    output logic                       tx_clear,
    output logic [DMSB:0]              tx_wdata,
    input  logic                       tx_empty
`ifdef LSRT_SCHED_TIMEOUT_EN
    ,
    input  logic [TMSB:0]              tmo,
    output logic                       err
`endif
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int DW = DMSB + 1;

    if (NREQ < 2 || NREQ > 8 || TMSB == 0) begin : g_bad_param
        $error("lsrt_sched: unsupported parameter set");
    end

    typedef enum logic [2:0] {
        StIdle,
        StPush,
        StWbusy,
        StWdone,
        StClear
    } state_t;

    state_t         state;
    logic [IW-1:0]  last;
    logic [IW-1:0]  pick;
    logic           any_req;

`ifdef LSRT_SCHED_TIMEOUT_EN
    logic [TMSB:0]  cnt;
    logic           tmo_on;
    logic           tmo_hit;

    assign tmo_hit = tmo_on && (cnt == '0);
`endif

    // Lowest offset from last+1 wins; iterating downwards lets the nearest match overwrite.
    always_comb begin
        int idx;
        pick    = last;
        any_req = 1'b0;
        idx     = 0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = (int'(last) + k) % int'(NREQ);
            if (req[idx]) begin
                pick    = IW'(idx);
                any_req = 1'b1;
            end
        end
    end

    assign busy = (state != StIdle);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= StIdle;
            last     <= IW'(NREQ - 1);
            gnt      <= '0;
            done     <= '0;
            tx_push  <= 1'b0;
            tx_clear <= 1'b0;
            tx_wdata <= '0;
`ifdef LSRT_SCHED_TIMEOUT_EN
            cnt      <= '0;
            tmo_on   <= 1'b0;
            err      <= 1'b0;
`endif
        end else if (setn) begin
            done <= '0;
`ifdef LSRT_SCHED_TIMEOUT_EN
            err  <= 1'b0;
            if ((state == StWbusy || state == StWdone) && tmo_on && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
`endif
            unique case (state)
                StIdle: begin
                    // Holding off while done is visible spaces pushes and lets req drop in time.
                    if (any_req && tx_empty && done == '0) begin
                        last  <= pick;
                        state <= StPush;
                    end
                end
                StPush: begin
                    gnt      <= NREQ'(1) << last;
                    tx_wdata <= wdata_in[int'(last)*DW +: DW];
                    tx_push  <= ~tx_push;
`ifdef LSRT_SCHED_TIMEOUT_EN
                    cnt      <= tmo;
                    tmo_on   <= (tmo != '0);
`endif
                    state    <= StWbusy;
                end
                StWbusy: begin
`ifdef LSRT_SCHED_TIMEOUT_EN
                    if (tmo_hit) begin
                        state <= StClear;
                    end else
`endif
                    if (!tx_empty) begin
                        state <= StWdone;
                    end
                end
                StWdone: begin
`ifdef LSRT_SCHED_TIMEOUT_EN
                    if (tmo_hit) begin
                        state <= StClear;
                    end else
`endif
                    if (tx_empty) begin
                        done  <= gnt;
                        gnt   <= '0;
                        state <= StIdle;
                    end
                end
`ifdef LSRT_SCHED_TIMEOUT_EN
                StClear: begin
                    tx_clear <= ~tx_clear;
                    err      <= 1'b1;
                    done     <= gnt;
                    gnt      <= '0;
                    state    <= StIdle;
                end
`endif
                default: begin
                    gnt   <= '0;
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsrt_sched.sv
// Directed bench for lsrt_sched with a behavioural lstx serialiser and an expected-transfer queue.
// Timeout checks are compiled only when LSRT_SCHED_TIMEOUT_EN is defined.
module tb_lsrt_sched;

    localparam int NREQ = 4;
    localparam int DW   = 10;

    typedef struct {
        int            idx;
        logic [DW-1:0] data;
    } item_t;

    logic                 clk = 1'b0;
    logic                 rstn = 1'b0;
    logic                 setn = 1'b1;
    logic [NREQ-1:0]      req = '0;
    logic [NREQ*DW-1:0]   wdata_in;
    logic [NREQ-1:0]      gnt;
    logic [NREQ-1:0]      done;
    logic                 busy;
    logic                 tx_push;
    logic                 tx_clear;
    logic [DW-1:0]        tx_wdata;
    logic                 tx_empty;
`ifdef LSRT_SCHED_TIMEOUT_EN
    logic [15:0]          tmo = '0;
    logic                 err;
`endif

    logic [DW-1:0] words [NREQ] = '{10'h0C3, 10'h2A5, 10'h15A, 10'h3F0};
    assign wdata_in = {words[3], words[2], words[1], words[0]};

    item_t sb[$];
    item_t cur;
    int    checks = 0;
    int    errors = 0;
    int    exp_last = NREQ - 1;
    logic  exp_push = 1'b0;
    logic  force_empty = 1'b0;

    always #5 clk = ~clk;

    lsrt_sched #(
        .NREQ(NREQ),
        .DMSB(DW - 1),
        .TMSB(15)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .setn     (setn),
        .req      (req),
        .wdata_in (wdata_in),
        .gnt      (gnt),
        .done     (done),
        .busy     (busy),
        .tx_push  (tx_push),
        .tx_clear (tx_clear),
        .tx_wdata (tx_wdata),
        .tx_empty (tx_empty)
`ifdef LSRT_SCHED_TIMEOUT_EN
        ,
        .tmo      (tmo),
        .err      (err)
`endif
    );

    // lstx stand-in: each push toggle shifts the word out LSB first, empty low meanwhile.
    logic          push_prev;
    logic          empty_q;
    logic [DW-1:0] sh;
    logic [DW-1:0] rx;
    int            nbits;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            push_prev <= 1'b0;
            empty_q   <= 1'b1;
            sh        <= '0;
            rx        <= '0;
            nbits     <= 0;
        end else begin
            push_prev <= tx_push;
            if (tx_push != push_prev) begin
                sh      <= tx_wdata;
                nbits   <= DW;
                empty_q <= 1'b0;
            end else if (nbits > 0) begin
                rx    <= {sh[0], rx[DW-1:1]};
                sh    <= sh >> 1;
                nbits <= nbits - 1;
                if (nbits == 1) empty_q <= 1'b1;
            end
        end
    end

    assign tx_empty = empty_q | force_empty;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_item(input int idx);
        sb.push_back('{idx, words[idx]});
        exp_last = idx;
    endtask

    task automatic wait_gnt();
        int n = 0;
        cur = sb.pop_front();
        while (gnt == '0 && n < 200) begin
            step();
            n++;
        end
        exp_push = ~exp_push;
        check($sformatf("gnt[%0d]", cur.idx), 32'(gnt), 32'(1 << cur.idx));
        check("busy_in_xfer", 32'(busy), 32'd1);
        check("tx_wdata", 32'(tx_wdata), 32'(cur.data));
        check("tx_push", 32'(tx_push), 32'(exp_push));
    endtask

    task automatic wait_done();
        int n = 0;
        while (done == '0 && n < 200) begin
            step();
            n++;
        end
        check($sformatf("done[%0d]", cur.idx), 32'(done), 32'(1 << cur.idx));
        check("serial_word", 32'(rx), 32'(cur.data));
        check("gnt_cleared", 32'(gnt), 32'd0);
        check("busy_after", 32'(busy), 32'd0);
        step();
        check("done_one_cycle", 32'(done), 32'd0);
    endtask

    task automatic wait_tx_low();
        int n = 0;
        while (tx_empty && n < 50) begin
            step();
            n++;
        end
        check("tx_empty_low", 32'(tx_empty), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        #12;
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_push", 32'(tx_push), 32'd0);
        check("rst_clear", 32'(tx_clear), 32'd0);
        check("rst_wdata", 32'(tx_wdata), 32'd0);
        step();
        rstn = 1'b1;
        step();

        // Single transfer from requester 1.
        req = 4'b0010;
        push_item(1);
        wait_gnt();
        wait_done();
        req = 4'b0000;
        step();
        check("idle_busy", 32'(busy), 32'd0);

        // Fairness: all requesting, grants rotate from the last winner.
        req = 4'b1111;
        for (int k = 0; k < 8; k++) push_item((exp_last + 1) % NREQ);
        for (int k = 0; k < 8; k++) begin
            wait_gnt();
            if (k == 7) begin
                n = 0;
                while (done == '0 && n < 200) begin
                    step();
                    n++;
                end
                req = 4'b0000;
                check($sformatf("done[%0d]", cur.idx), 32'(done), 32'(1 << cur.idx));
                check("serial_word", 32'(rx), 32'(cur.data));
                step();
            end else begin
                wait_done();
            end
        end

        // Asynchronous reset in WDONE abandons the transfer.
        req = 4'b0001;
        push_item(0);
        wait_gnt();
        wait_tx_low();
        step();
        step();
        rstn = 1'b0;
        #1;
        check("mid_rst_gnt", 32'(gnt), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_push", 32'(tx_push), 32'd0);
        check("mid_rst_wdata", 32'(tx_wdata), 32'd0);
        exp_push = 1'b0;
        exp_last = NREQ - 1;
        step();
        rstn = 1'b1;
        push_item(0);
        wait_gnt();
        wait_done();

        // Requester 2 drops its request while its transfer is in flight.
        req = 4'b0101;
        push_item(2);
        push_item(0);
        wait_gnt();
        req = 4'b0001;
        wait_done();
        wait_gnt();
        n = 0;
        while (done == '0 && n < 200) begin
            step();
            n++;
        end
        req = 4'b0000;
        check("drop_next_done", 32'(done), 32'b0001);
        step();

        // setn low for 20 cycles in WDONE freezes the scheduler.
        req = 4'b0010;
        push_item(1);
        wait_gnt();
        wait_tx_low();
        step();
        setn = 1'b0;
        repeat (20) step();
        check("frz_gnt", 32'(gnt), 32'b0010);
        check("frz_busy", 32'(busy), 32'd1);
        check("frz_done", 32'(done), 32'd0);
        check("frz_push", 32'(tx_push), 32'(exp_push));
        setn = 1'b1;
        n = 0;
        while (done == '0 && n < 200) begin
            step();
            n++;
        end
        req = 4'b0000;
        check("frz_resume_done", 32'(done), 32'b0010);
        check("frz_resume_busy", 32'(busy), 32'd0);
        step();

`ifdef LSRT_SCHED_TIMEOUT_EN
        // tx_empty never drops: 17 WBUSY cycles then CLEAR.
        force_empty = 1'b1;
        tmo = 16'd16;
        req = 4'b0100;
        push_item(2);
        wait_gnt();
        n = 0;
        while (tx_clear == 1'b0 && n < 50) begin
            step();
            n++;
        end
        check("tmo_cycles", 32'(n), 32'd18);
        check("tmo_err", 32'(err), 32'd1);
        check("tmo_done", 32'(done), 32'b0100);
        check("tmo_busy", 32'(busy), 32'd0);
        req = 4'b0000;
        step();
        check("tmo_err_pulse", 32'(err), 32'd0);
        check("tmo_done_pulse", 32'(done), 32'd0);
        force_empty = 1'b0;
        tmo = '0;
        step();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
